// File: rtl/pong_ctrl_pkg.sv
// Shared constants and types for the UART keyboard control path:
// ASCII command keys, case-fold mask and the serial receiver state encoding.
package pong_ctrl_pkg;

    localparam logic [7:0] KEY_P1_UP = 8'h77;
    localparam logic [7:0] KEY_P1_DN = 8'h73;
    localparam logic [7:0] KEY_P2_UP = 8'h6F;
    localparam logic [7:0] KEY_P2_DN = 8'h6C;
    localparam logic [7:0] KEY_START = 8'h20;
    localparam logic [7:0] KEY_CR    = 8'h0D;
    localparam logic [7:0] CASE_FOLD = 8'h20;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Maps upper-case letters onto lower case; only meaningful for letter keys.
    function automatic logic [7:0] fold_case(input logic [7:0] b);
        return b | CASE_FOLD;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver: input synchronizer, baud counter and framing FSM.
// A good frame updates rx_byte and pulses rx_valid one cycle after the stop sample.
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    import pong_ctrl_pkg::*;

    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta, rxs;
    rx_state_t       state, state_nxt;
    logic [BCW-1:0]  bcnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            bit_end, half_end, shift_en, stop_ok, stop_bad, bcnt_clr;

    // Preset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (!rxs) state_nxt = RX_START;
            RX_START: if (half_end) state_nxt = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = RX_STOP;
            RX_STOP:  if (bit_end) state_nxt = rxs ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rxs) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        bit_end  = (bcnt == BIT_LAST);
        half_end = (bcnt == HALF_LAST);
        shift_en = (state == RX_DATA) && bit_end;
        stop_ok  = (state == RX_STOP) && bit_end && rxs;
        stop_bad = (state == RX_STOP) && bit_end && !rxs;
        bcnt_clr = (state_nxt != state) || shift_en ||
                   (state == RX_IDLE) || (state == RX_BREAK);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt      <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= stop_ok;
            frame_err <= stop_bad;
            if (stop_ok)  rx_byte <= shreg;
            if (bcnt_clr) bcnt <= '0;
            else          bcnt <= bcnt + BCW'(1);
            if (state != RX_DATA) bit_idx <= '0;
            else if (shift_en)    bit_idx <= bit_idx + 3'd1;
            if (shift_en) shreg <= {rxs, shreg[7:1]};
        end
    end

endmodule

// File: rtl/uart_ctrl_decoder.sv
// UART keyboard front end: decodes received keys into held paddle levels
// with per-player hold timers, plus a one-cycle start pulse.
module uart_ctrl_decoder #(
    parameter int CLK_HZ      = 50000000,
    parameter int BAUD        = 115200,
    parameter int HOLD_CYCLES = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       p1_up,
    output logic       p1_down,
    output logic       p2_up,
    output logic       p2_down,
    output logic       start_trigger,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);
    import pong_ctrl_pkg::*;

    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [22:0] HOLD_LOAD    = 23'(HOLD_CYCLES - 1);

    logic [7:0]       key;
    logic [1:0]       press_up, press_dn, lvl_up, lvl_dn;
    logic [1:0][22:0] hold;
    logic             start_hit;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    // Start keys are matched unfolded: folding would alias 0x00 onto space.
    always_comb begin
        key         = fold_case(rx_byte);
        press_up[0] = rx_valid && (key == KEY_P1_UP);
        press_dn[0] = rx_valid && (key == KEY_P1_DN);
        press_up[1] = rx_valid && (key == KEY_P2_UP);
        press_dn[1] = rx_valid && (key == KEY_P2_DN);
        start_hit   = rx_valid && (rx_byte == KEY_START || rx_byte == KEY_CR);
    end

    // Levels are only ever set together with a reload, so an idle timer means expired.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold          <= '0;
            lvl_up        <= '0;
            lvl_dn        <= '0;
            start_trigger <= 1'b0;
        end else begin
            start_trigger <= start_hit;
            for (int p = 0; p < 2; p++) begin
                if (press_up[p] || press_dn[p]) begin
                    hold[p]   <= HOLD_LOAD;
                    lvl_up[p] <= press_up[p];
                    lvl_dn[p] <= press_dn[p];
                end else if (hold[p] == '0) begin
                    lvl_up[p] <= 1'b0;
                    lvl_dn[p] <= 1'b0;
                end else begin
                    hold[p] <= hold[p] - 23'd1;
                end
            end
        end
    end

    assign p1_up   = lvl_up[0];
    assign p1_down = lvl_dn[0];
    assign p2_up   = lvl_up[1];
    assign p2_down = lvl_dn[1];

endmodule
